// File: rtl/nn_mac_sequencer_if.sv
// Bus/RAM-side signal bundle for the MAC sequencer.
// The master modport is the compute engine; the slave modport is the CSR/RAM side.
interface nn_mac_sequencer_if #(
    parameter int PADDR_W = 11,
    parameter int WADDR_W = 13
);
    logic                     start_calc;
    logic [PADDR_W-1:0]       pixel_raddr;
    logic [WADDR_W-1:0]       weight_raddr;
    logic                     mem_re;
    logic [7:0]               pixel_rdata;
    logic signed [7:0]        weight_rdata;
    logic [3:0]               output_address;
    logic signed [16:0]       result_output;
    logic                     done_calc;
    logic                     busy;

    modport master (
        input  start_calc, pixel_rdata, weight_rdata, output_address,
        output pixel_raddr, weight_raddr, mem_re, result_output, done_calc, busy
    );

    modport slave (
        output start_calc, pixel_rdata, weight_rdata, output_address,
        input  pixel_raddr, weight_raddr, mem_re, result_output, done_calc, busy
    );
endinterface

// File: rtl/nn_mac_sequencer.sv
// Dot-product engine: streams N_IN pixel/weight pairs per output neuron,
// accumulates, scales/saturates/ReLUs, and stores N_OUT results in a small
// register file read combinationally by the bus interface.
module nn_mac_sequencer #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 10,
    parameter int PADDR_W = 11,
    parameter int WADDR_W = 13,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 8,
    parameter int RELU    = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    nn_mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, STORE, DONE} state_t;

    localparam int RES_W  = 17;
    localparam int PROD_W = 16;

    state_t               state_q, state_d;
    logic                 start_q;
    logic [3:0]           row_q, row_d;
    logic [PADDR_W-1:0]   paddr_q, paddr_d;
    logic [WADDR_W-1:0]   waddr_q, waddr_d;
    logic                 drain_q, drain_d;
    logic                 done_q;
    logic                 launch;
    logic                 acc_clr;
    logic                 store_en;

    logic                 vld_p0;
    logic                 vld_p1;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [RES_W-1:0]  result_q [16];

    // Scale by SHIFT, clamp to the 17-bit signed range, then optional ReLU.
    function automatic logic signed [RES_W-1:0] form_result(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] v;
        logic signed [RES_W-1:0] r;
        v = acc >>> SHIFT;
        if (v > ACC_W'(65535))
            r = 17'h0FFFF;
        else if (v < ACC_W'(-65536))
            r = 17'h10000;
        else
            r = v[RES_W-1:0];
        if (RELU != 0 && r[RES_W-1])
            r = '0;
        return r;
    endfunction

    // Only a fresh 0->1 transition of the CSR bit counts as a launch request.
    assign launch = bus.start_calc & ~start_q;

    // Next-state and per-state control decisions.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        paddr_d  = paddr_q;
        waddr_d  = waddr_q;
        drain_d  = drain_q;
        acc_clr  = 1'b0;
        store_en = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = RUN;
                    row_d   = '0;
                    paddr_d = '0;
                    waddr_d = '0;
                    acc_clr = 1'b1;
                end
            end
            RUN: begin
                if (paddr_q == PADDR_W'(N_IN - 1)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    paddr_d = paddr_q + PADDR_W'(1);
                    waddr_d = waddr_q + WADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q)
                    state_d = STORE;
                else
                    drain_d = 1'b1;
            end
            STORE: begin
                store_en = 1'b1;
                acc_clr  = 1'b1;
                if (row_q == 4'(N_OUT - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                    row_d   = row_q + 4'd1;
                    paddr_d = '0;
                    // Weight rows are contiguous, so the next row starts right after the last address issued.
                    waddr_d = waddr_q + WADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; done_calc trails entry into DONE by one edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            row_q   <= '0;
            paddr_q <= '0;
            waddr_q <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start_calc;
            row_q   <= row_d;
            paddr_q <= paddr_d;
            waddr_q <= waddr_d;
            drain_q <= drain_d;
            done_q  <= (state_q == DONE);
        end
    end

    // Stage p0: RAM data valid one cycle after the read strobe; p1: product valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= bus.mem_re;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p1: pixel zero-extended, weight sign-extended, 16-bit signed product.
    always_ff @(posedge clk) begin
        prod_p1 <= $signed({8'b0, bus.pixel_rdata}) * $signed({{8{bus.weight_rdata[7]}}, bus.weight_rdata});
    end

    // Stage p2: accumulate sign-extended products; cleared at launch and after each store.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            acc_q <= '0;
        else if (acc_clr)
            acc_q <= '0;
        else if (vld_p1)
            acc_q <= acc_q + ACC_W'(prod_p1);
    end

    // Result file: one entry written per row at STORE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 16; k++)
                result_q[k] <= '0;
        end else if (store_en) begin
            result_q[row_q] <= form_result(acc_q);
        end
    end

    assign bus.mem_re        = (state_q == RUN);
    assign bus.pixel_raddr   = paddr_q;
    assign bus.weight_raddr  = waddr_q;
    assign bus.busy          = (state_q == RUN) || (state_q == DRAIN) || (state_q == STORE);
    assign bus.done_calc     = done_q;
    assign bus.result_output = (int'(bus.output_address) < N_OUT) ? result_q[bus.output_address] : '0;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Bench for nn_mac_sequencer: three instances (small/no-ReLU, small/ReLU,
// default parameters) with behavioural RAMs and a result scoreboard.
module tb_nn_mac_sequencer;
    logic clk = 1'b0;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nn_mac_sequencer_if ifa ();
    nn_mac_sequencer_if ifb ();
    nn_mac_sequencer_if ifc ();

    nn_mac_sequencer #(.N_IN(4), .N_OUT(2), .SHIFT(0), .RELU(0)) u_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
    nn_mac_sequencer #(.N_IN(4), .N_OUT(2), .SHIFT(0), .RELU(1)) u_b (.clk(clk), .n_rst(n_rst), .bus(ifb));
    nn_mac_sequencer u_c (.clk(clk), .n_rst(n_rst), .bus(ifc));

    logic [7:0]        pix_mem [4];
    logic signed [7:0] wt_mem  [8];
    logic [7:0]        pix_c;
    logic signed [7:0] wt_c;

    int exp_q [$];
    int pa_obs [$];
    int wa_obs [$];

    // One-cycle-latency RAM models
    always @(posedge clk) begin
        if (ifa.mem_re) begin
            ifa.pixel_rdata  <= pix_mem[ifa.pixel_raddr[1:0]];
            ifa.weight_rdata <= wt_mem[ifa.weight_raddr[2:0]];
        end
        if (ifb.mem_re) begin
            ifb.pixel_rdata  <= pix_mem[ifb.pixel_raddr[1:0]];
            ifb.weight_rdata <= wt_mem[ifb.weight_raddr[2:0]];
        end
        if (ifc.mem_re) begin
            ifc.pixel_rdata  <= pix_c;
            ifc.weight_rdata <= wt_c;
        end
    end

    // Address monitor for instance a
    always @(posedge clk) begin
        if (ifa.mem_re) begin
            pa_obs.push_back(int'(ifa.pixel_raddr));
            wa_obs.push_back(int'(ifa.weight_raddr));
        end
    end

    function automatic int model(input longint dot, input int sh, input bit relu);
        longint v;
        v = dot >>> sh;
        if (v > 65535)  v = 65535;
        if (v < -65536) v = -65536;
        if (relu && v < 0) v = 0;
        return int'(v);
    endfunction

    function automatic longint dot_row(input int row);
        longint s = 0;
        for (int k = 0; k < 4; k++)
            s += longint'(pix_mem[k]) * longint'(wt_mem[row*4 + k]);
        return s;
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return ifa.done_calc;
            1:       return ifb.done_calc;
            default: return ifc.done_calc;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    function automatic logic get_mem_re(input int sel);
        case (sel)
            0:       return ifa.mem_re;
            1:       return ifb.mem_re;
            default: return ifc.mem_re;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       ifa.start_calc = v;
            1:       ifb.start_calc = v;
            default: ifc.start_calc = v;
        endcase
    endtask

    task automatic read_res(input int sel, input int a, output int r);
        case (sel)
            0:       ifa.output_address = 4'(a);
            1:       ifb.output_address = 4'(a);
            default: ifc.output_address = 4'(a);
        endcase
        #1;
        case (sel)
            0:       r = int'(ifa.result_output);
            1:       r = int'(ifb.result_output);
            default: r = int'(ifc.result_output);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop then raise start; returns just after the edge that samples it high.
    task automatic launch(input int sel);
        @(negedge clk);
        set_start(sel, 1'b0);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Counts edges (continuing from n0) until done_calc rises; -1 on timeout.
    task automatic wait_done(input int sel, input int n0, input int limit, output int edges);
        logic prev, cur;
        prev  = get_done(sel);
        edges = -1;
        for (int n = n0 + 1; n <= limit; n++) begin
            tick();
            cur = get_done(sel);
            if (cur && !prev) begin
                edges = n;
                break;
            end
            prev = cur;
        end
    endtask

    task automatic test_reset();
        int r;
        n_rst = 1'b0;
        ifa.start_calc = 0; ifb.start_calc = 0; ifc.start_calc = 0;
        ifa.output_address = 0; ifb.output_address = 0; ifc.output_address = 0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_busy(s) !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got %0b want 0", s, get_busy(s)); end
            checks++;
            if (get_done(s) !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] got %0b want 0", s, get_done(s)); end
            checks++;
            if (get_mem_re(s) !== 1'b0) begin failures++; $display("FAIL reset_mem_re[%0d] got %0b want 0", s, get_mem_re(s)); end
            read_res(s, 0, r);
            checks++;
            if (r !== 0) begin failures++; $display("FAIL reset_result[%0d] got %0d want 0", s, r); end
        end
        checks++;
        if (ifa.pixel_raddr !== 11'd0 || ifa.weight_raddr !== 13'd0) begin
            failures++;
            $display("FAIL reset_addr got p=%0d w=%0d want 0/0", ifa.pixel_raddr, ifa.weight_raddr);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_basic_mac();
        int e, r, x;
        pix_mem = '{8'd1, 8'd2, 8'd3, 8'd4};
        wt_mem  = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd2, 8'sd0, 8'sd3};
        for (int row = 0; row < 2; row++) exp_q.push_back(model(dot_row(row), 0, 1'b0));
        pa_obs.delete();
        wa_obs.delete();
        launch(0);
        wait_done(0, 0, 200, e);
        checks++;
        if (e !== 15) begin failures++; $display("FAIL basic_latency got %0d want 15", e); end
        for (int a = 0; a < 2; a++) begin
            x = exp_q.pop_front();
            read_res(0, a, r);
            checks++;
            if (r !== x) begin failures++; $display("FAIL basic_result[%0d] got %0d want %0d", a, r, x); end
        end
        checks++;
        if (wa_obs.size() !== 8) begin
            failures++; $display("FAIL basic_read_count got %0d want 8", wa_obs.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wa_obs[k] !== k || pa_obs[k] !== k % 4) begin
                    failures++;
                    $display("FAIL basic_addr[%0d] got p=%0d w=%0d want p=%0d w=%0d", k, pa_obs[k], wa_obs[k], k % 4, k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, r, x;
        // start still held high from the previous run: must not relaunch
        repeat (30) tick();
        checks++;
        if (ifa.busy !== 1'b0 || ifa.done_calc !== 1'b1 || ifa.mem_re !== 1'b0) begin
            failures++;
            $display("FAIL held_start got busy=%0b done=%0b mem_re=%0b want 0/1/0", ifa.busy, ifa.done_calc, ifa.mem_re);
        end
        for (int row = 0; row < 2; row++) exp_q.push_back(model(dot_row(row), 0, 1'b0));
        launch(0);
        checks++;
        if (ifa.busy !== 1'b1 || ifa.done_calc !== 1'b1) begin
            failures++; $display("FAIL relaunch_edge got busy=%0b done=%0b want 1/1", ifa.busy, ifa.done_calc);
        end
        tick();
        checks++;
        if (ifa.done_calc !== 1'b0) begin failures++; $display("FAIL relaunch_done_clear got %0b want 0", ifa.done_calc); end
        @(negedge clk);
        set_start(0, 1'b0);
        tick();
        @(negedge clk);
        set_start(0, 1'b1);
        tick();
        wait_done(0, 3, 200, e);
        checks++;
        if (e !== 15) begin failures++; $display("FAIL busy_pulse_latency got %0d want 15", e); end
        for (int a = 0; a < 2; a++) begin
            x = exp_q.pop_front();
            read_res(0, a, r);
            checks++;
            if (r !== x) begin failures++; $display("FAIL b2b_result[%0d] got %0d want %0d", a, r, x); end
        end
    endtask

    task automatic test_saturation_relu();
        int e, r, x;
        pix_mem = '{8'd255, 8'd255, 8'd255, 8'd255};
        wt_mem  = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
        for (int row = 0; row < 2; row++) exp_q.push_back(model(dot_row(row), 0, 1'b0));
        for (int row = 0; row < 2; row++) exp_q.push_back(model(dot_row(row), 0, 1'b1));
        @(negedge clk);
        set_start(0, 1'b0); set_start(1, 1'b0);
        @(negedge clk);
        set_start(0, 1'b1); set_start(1, 1'b1);
        tick();
        wait_done(0, 0, 200, e);
        checks++;
        if (e !== 15) begin failures++; $display("FAIL sat_latency got %0d want 15", e); end
        checks++;
        if (ifb.done_calc !== 1'b1) begin failures++; $display("FAIL relu_done got %0b want 1", ifb.done_calc); end
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 2; a++) begin
                x = exp_q.pop_front();
                read_res(s, a, r);
                checks++;
                if (r !== x) begin failures++; $display("FAIL sat_result[%0d][%0d] got %0d want %0d", s, a, r, x); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int r;
        launch(0);
        tick();
        tick();
        checks++;
        if (ifa.busy !== 1'b1 || ifa.mem_re !== 1'b1) begin
            failures++; $display("FAIL midrun_active got busy=%0b mem_re=%0b want 1/1", ifa.busy, ifa.mem_re);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (ifa.busy !== 1'b0 || ifa.done_calc !== 1'b0 || ifa.mem_re !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%0b done=%0b mem_re=%0b want 0/0/0", ifa.busy, ifa.done_calc, ifa.mem_re);
        end
        for (int a = 0; a < 2; a++) begin
            read_res(0, a, r);
            checks++;
            if (r !== 0) begin failures++; $display("FAIL midrun_result[%0d] got %0d want 0", a, r); end
        end
        set_start(0, 1'b0); set_start(1, 1'b0); set_start(2, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_shift_default();
        int e, r, x;
        pix_c = 8'd255;
        wt_c  = 8'sd1;
        for (int row = 0; row < 10; row++) exp_q.push_back(model(longint'(784) * 255 * 1, 8, 1'b1));
        launch(2);
        wait_done(2, 0, 9000, e);
        checks++;
        if (e !== 10 * (784 + 3) + 1) begin failures++; $display("FAIL shift_latency got %0d want %0d", e, 10 * 787 + 1); end
        for (int a = 0; a < 10; a++) begin
            x = exp_q.pop_front();
            read_res(2, a, r);
            checks++;
            if (r !== x) begin failures++; $display("FAIL shift_result[%0d] got %0d want %0d", a, r, x); end
        end
    endtask

    task automatic test_out_of_range();
        int r;
        read_res(2, 15, r);
        checks++;
        if (r !== 0) begin failures++; $display("FAIL oor_addr15 got %0d want 0", r); end
        read_res(2, 10, r);
        checks++;
        if (r !== 0) begin failures++; $display("FAIL oor_addr10 got %0d want 0", r); end
        read_res(2, 9, r);
        checks++;
        if (r !== 780) begin failures++; $display("FAIL oor_addr9_inrange got %0d want 780", r); end
    endtask

    initial begin
        test_reset();
        test_basic_mac();
        test_back_to_back();
        test_saturation_relu();
        test_reset_mid_run();
        test_shift_default();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
